// File: rtl/cpu_run_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_pkg
// Shared types and constants for the CPU run-control sequencer.
//   state_t    : run-control FSM state encoding (3-bit)
//   HALT_WORD  : instruction word that stops the program when seen in decode
//   NOP_WORD   : instruction word the pipeline uses as a bubble
//   is_halt()  : decode-stage halt-word compare
// -----------------------------------------------------------------------------
package cpu_run_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_DUMP_RD  = 3'd3,
      ST_DUMP_OUT = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

   // True when the decode-stage instruction is the halt word
   function automatic logic is_halt(input logic [31:0] word);
      return (word == HALT_WORD);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_if
// Memory-borrow and dump-stream bundle between the run controller and its
// consumer / MainMemory.
//   DumpSel     : 1 = memory address comes from DumpAddr
//   DumpAddr    : word address being dumped
//   MemReadData : MainMemory read data
//   DumpData    : dumped word
//   DumpValid   : DumpData valid
//   DumpReady   : consumer accepts DumpData
// master = run controller, slave = memory/consumer side.
// -----------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              DumpSel;
   logic [ADDR_W-1:0] DumpAddr;
   logic [31:0]       MemReadData;
   logic [31:0]       DumpData;
   logic              DumpValid;
   logic              DumpReady;

   modport master (
      output DumpSel,
      output DumpAddr,
      output DumpData,
      output DumpValid,
      input  MemReadData,
      input  DumpReady
   );

   modport slave (
      input  DumpSel,
      input  DumpAddr,
      input  DumpData,
      input  DumpValid,
      output MemReadData,
      output DumpReady
   );
endinterface

// File: rtl/cpu_run_ctrl_dump_sequencer.sv
// -----------------------------------------------------------------------------
// dump_sequencer
// Walks MainMemory addresses 0..MEM_WORDS-1 and presents each word on a
// valid/ready stream. One read cycle (DUMP_RD) followed by one or more
// output cycles (DUMP_OUT) per word.
//   i_clk, i_rst    : clock, async active-high reset
//   i_go            : one-cycle pulse, starts a dump at address 0
//   i_mem_rdata     : MainMemory read data for o_addr
//   i_ready         : consumer ready
//   o_addr          : current word index / memory address
//   o_data, o_valid : dump stream
//   o_busy          : dump in progress (memory port borrowed)
//   o_last_done     : final word accepted this cycle
// -----------------------------------------------------------------------------
module dump_sequencer
   import cpu_run_pkg::*;
#(
   parameter int MEM_WORDS = 512,
   parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_go,
   input  logic [31:0]       i_mem_rdata,
   input  logic              i_ready,
   output logic [ADDR_W-1:0] o_addr,
   output logic [31:0]       o_data,
   output logic              o_valid,
   output logic              o_busy,
   output logic              o_last_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_WORDS - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic              r_valid;
   logic              w_accept;
   logic              w_last_done;

   // Dump state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_go) begin
               w_next_state = ST_DUMP_RD;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_DUMP_RD: begin
            w_next_state = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            if (r_valid && i_ready) begin
               w_accept = 1'b1;
               if (r_addr == LAST_IDX) begin
                  w_last_done  = 1'b1;
                  w_next_state = ST_IDLE;
               end else begin
                  w_next_state = ST_DUMP_RD;
               end
            end else begin
               w_next_state = ST_DUMP_OUT;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Index, captured word and valid flag; data/address hold while stalled
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_addr  <= {ADDR_W{1'b0}};
         r_data  <= 32'h0000_0000;
         r_valid <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && i_go) begin
            r_addr <= {ADDR_W{1'b0}};
         end else if (r_state == ST_DUMP_RD) begin
            r_data  <= i_mem_rdata;
            r_valid <= 1'b1;
         end else if (w_accept) begin
            r_valid <= 1'b0;
            // Index stays on the last word so DumpAddr is meaningful in DONE
            if (!w_last_done) begin
               r_addr <= r_addr + ADDR_W'(1);
            end
         end
      end
   end

   assign o_addr      = r_addr;
   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_busy      = (r_state == ST_DUMP_RD) || (r_state == ST_DUMP_OUT);
   assign o_last_done = w_last_done;

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run-control sequencer for the 5-stage CPU: runs the pipeline after START,
// stops fetch on the halt word in decode, drains in-flight instructions, then
// dumps MainMemory over a valid/ready stream.
//   CLOCK, RESET : clock, async active-high reset
//   START        : one-cycle start pulse (IDLE only)
//   Inst_D       : instruction in the IF/ID register
//   PipeEn       : PC and pipeline register enable
//   PcHold       : freeze PC_REG
//   FetchKill    : flush IF/ID to NOP on the next edge
//   dump_if      : memory-borrow and dump stream (master side)
//   CycleCount   : RUN+DRAIN cycles, saturating
//   Timeout      : watchdog fired (sticky until RESET/START)
//   Done         : dump complete
// -----------------------------------------------------------------------------
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int          MEM_WORDS    = 512,
   parameter int          ADDR_W       = $clog2(MEM_WORDS),
   parameter int          DRAIN_CYCLES = 3,
   parameter logic [31:0] MAX_CYCLES   = 32'd1_000_000,
   parameter int          CNT_W        = 32
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             START,
   input  logic [31:0]      Inst_D,
   output logic             PipeEn,
   output logic             PcHold,
   output logic             FetchKill,
   cpu_run_ctrl_if.master   dump_if,
   output logic [CNT_W-1:0] CycleCount,
   output logic             Timeout,
   output logic             Done
);

   // A zero drain length would never reach the exit count, so it runs one cycle
   localparam int               DRAIN_LOAD = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
   localparam int               DRAIN_W    = $clog2(DRAIN_LOAD + 1);
   localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(MAX_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

   state_t             r_state;
   state_t             w_next_state;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [CNT_W-1:0]   r_cycle_count;
   logic               r_timeout;
   logic               r_done;

   logic               w_halt;
   logic               w_wd_hit;
   logic               w_pipe_en;
   logic               w_pc_hold;
   logic               w_fetch_kill;
   logic               w_dump_sel;
   logic               w_dump_go;
   logic               w_start_run;
   logic               w_enter_drain;
   logic               w_last_done;
   logic               w_dump_busy;
   logic [ADDR_W-1:0]  w_dump_addr;
   logic [31:0]        w_dump_data;
   logic               w_dump_valid;

   assign w_halt   = is_halt(Inst_D);
   assign w_wd_hit = (r_cycle_count >= WD_LIMIT);

   // Run-control state register
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and state-decoded pipeline controls
   always_comb begin
      w_next_state = r_state;
      w_pipe_en    = 1'b0;
      w_pc_hold    = 1'b1;
      w_fetch_kill = 1'b0;
      w_dump_sel   = 1'b0;
      w_dump_go    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_RUN: begin
            w_pipe_en = 1'b1;
            w_pc_hold = 1'b0;
            // Halt wins over the watchdog: both drain, only halt kills IF/ID now
            if (w_halt) begin
               w_fetch_kill = 1'b1;
               w_next_state = ST_DRAIN;
            end else if (w_wd_hit) begin
               w_next_state = ST_DRAIN;
            end else begin
               w_next_state = ST_RUN;
            end
         end
         ST_DRAIN: begin
            w_pipe_en    = 1'b1;
            w_fetch_kill = 1'b1;
            if (r_drain_cnt <= DRAIN_W'(1)) begin
               w_dump_go    = 1'b1;
               w_next_state = ST_DUMP_RD;
            end else begin
               w_next_state = ST_DRAIN;
            end
         end
         // ST_DUMP_RD here covers the whole dump; the sequencer tracks RD/OUT
         ST_DUMP_RD: begin
            w_dump_sel = 1'b1;
            if (w_last_done) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_DUMP_RD;
            end
         end
         ST_DONE: begin
            w_next_state = ST_DONE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign w_start_run   = (r_state == ST_IDLE) && START;
   assign w_enter_drain = (r_state == ST_RUN) && (w_next_state == ST_DRAIN);

   // Drain countdown loaded on RUN exit
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_drain_cnt <= {DRAIN_W{1'b0}};
      end else begin
         if (w_enter_drain) begin
            r_drain_cnt <= DRAIN_W'(DRAIN_LOAD);
         end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
         end
      end
   end

   // Saturating RUN+DRAIN cycle counter and sticky watchdog flag
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_cycle_count <= {CNT_W{1'b0}};
         r_timeout     <= 1'b0;
      end else begin
         if (w_start_run) begin
            r_cycle_count <= {CNT_W{1'b0}};
            r_timeout     <= 1'b0;
         end else begin
            if ((r_state == ST_RUN || r_state == ST_DRAIN) && r_cycle_count != CNT_SAT) begin
               r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            if (r_state == ST_RUN && w_wd_hit) begin
               r_timeout <= 1'b1;
            end
         end
      end
   end

   // Done flag, set as the final word is accepted
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_done <= 1'b0;
      end else begin
         if (r_state == ST_DUMP_RD && w_last_done) begin
            r_done <= 1'b1;
         end
      end
   end

   dump_sequencer #(
      .MEM_WORDS (MEM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_dump (
      .i_clk       (CLOCK),
      .i_rst       (RESET),
      .i_go        (w_dump_go),
      .i_mem_rdata (dump_if.MemReadData),
      .i_ready     (dump_if.DumpReady),
      .o_addr      (w_dump_addr),
      .o_data      (w_dump_data),
      .o_valid     (w_dump_valid),
      .o_busy      (w_dump_busy),
      .o_last_done (w_last_done)
   );

   assign PipeEn    = w_pipe_en;
   assign PcHold    = w_pc_hold;
   assign FetchKill = w_fetch_kill;

   // Address mux select follows the top FSM; the sequencer is busy for the same span
   assign dump_if.DumpSel   = w_dump_sel && w_dump_busy;
   assign dump_if.DumpAddr  = w_dump_addr;
   assign dump_if.DumpData  = w_dump_data;
   assign dump_if.DumpValid = w_dump_valid;

   assign CycleCount = r_cycle_count;
   assign Timeout    = r_timeout;
   assign Done       = r_done;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl with MEM_WORDS=4, DRAIN_CYCLES=3 and
// MAX_CYCLES=20; memory holds {1,2,3,4}.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP  = 32'h0000_0000;

   logic        CLOCK;
   logic        RESET;
   logic        START;
   logic [31:0] Inst_D;
   logic        PipeEn;
   logic        PcHold;
   logic        FetchKill;
   logic [31:0] CycleCount;
   logic        Timeout;
   logic        Done;

   logic [31:0] mem [0:3];

   int n_checks = 0;
   int n_errors = 0;

   cpu_run_ctrl_if #(.ADDR_W(2)) dif ();

   // Read data presented for the address on DumpAddr
   assign dif.MemReadData = mem[dif.DumpAddr];

   cpu_run_ctrl #(
      .MEM_WORDS    (4),
      .ADDR_W       (2),
      .DRAIN_CYCLES (3),
      .MAX_CYCLES   (32'd20),
      .CNT_W        (32)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .START      (START),
      .Inst_D     (Inst_D),
      .PipeEn     (PipeEn),
      .PcHold     (PcHold),
      .FetchKill  (FetchKill),
      .dump_if    (dif.master),
      .CycleCount (CycleCount),
      .Timeout    (Timeout),
      .Done       (Done)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      #3;
      RESET = 1'b0;
      tick();
   endtask

   task automatic pulse_start();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   // Entered in the first dump cycle; services the stream until Done
   task automatic run_dump(input int stall_word, input int stall_len, input int exp_cycles);
      int w = 0;
      int stall_left = stall_len;
      int cyc = 0;
      int guard = 0;
      logic hs;
      while (Done !== 1'b1 && guard < 200) begin
         guard++;
         if (dif.DumpSel) cyc++;
         if (dif.DumpValid) begin
            check_eq("dump_data", dif.DumpData, 32'(w + 1));
            check_eq("dump_addr", 32'(dif.DumpAddr), 32'(w));
            if (w == stall_word && stall_left > 0) begin
               dif.DumpReady = 1'b0;
               START = 1'b1;
               stall_left--;
            end else begin
               dif.DumpReady = 1'b1;
               START = 1'b0;
            end
         end else begin
            dif.DumpReady = 1'b1;
            START = 1'b0;
         end
         #1;
         hs = dif.DumpValid && dif.DumpReady;
         tick();
         if (hs) w++;
      end
      START = 1'b0;
      check_eq("dump_in_bound", 32'(guard < 200), 32'd1);
      check_eq("dump_words", 32'(w), 32'd4);
      check_eq("dump_cycles", 32'(cyc), 32'(exp_cycles));
      check_eq("done_dumpsel", 32'(dif.DumpSel), 32'd0);
      check_eq("done_pipeen", 32'(PipeEn), 32'd0);
   endtask

   initial begin
      mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
      RESET = 1'b1;
      START = 1'b0;
      Inst_D = NOP;
      dif.DumpReady = 1'b1;
      #12;
      // Reset state
      check_eq("rst_pipeen", 32'(PipeEn), 32'd0);
      check_eq("rst_pchold", 32'(PcHold), 32'd1);
      check_eq("rst_fetchkill", 32'(FetchKill), 32'd0);
      check_eq("rst_dumpsel", 32'(dif.DumpSel), 32'd0);
      check_eq("rst_dumpaddr", 32'(dif.DumpAddr), 32'd0);
      check_eq("rst_dumpdata", dif.DumpData, 32'd0);
      check_eq("rst_dumpvalid", 32'(dif.DumpValid), 32'd0);
      check_eq("rst_cycles", CycleCount, 32'd0);
      check_eq("rst_timeout", 32'(Timeout), 32'd0);
      check_eq("rst_done", 32'(Done), 32'd0);
      RESET = 1'b0;
      tick();

      // Reset mid-RUN
      pulse_start();
      check_eq("run_pipeen", 32'(PipeEn), 32'd1);
      tick(); tick(); tick();
      check_eq("run_cycles", CycleCount, 32'd3);
      #3;
      RESET = 1'b1;
      #1;
      check_eq("async_rst_pipeen", 32'(PipeEn), 32'd0);
      check_eq("async_rst_pchold", 32'(PcHold), 32'd1);
      check_eq("async_rst_cycles", CycleCount, 32'd0);
      #1;
      RESET = 1'b0;
      tick();
      check_eq("post_rst_pipeen", 32'(PipeEn), 32'd0);
      check_eq("post_rst_cycles", CycleCount, 32'd0);

      // Straight-line halt on 6th RUN cycle
      pulse_start();
      for (int i = 1; i <= 5; i++) begin
         check_eq("sl_run_pchold", 32'(PcHold), 32'd0);
         check_eq("sl_run_kill", 32'(FetchKill), 32'd0);
         tick();
      end
      Inst_D = HALT;
      #1;
      check_eq("sl_halt_kill", 32'(FetchKill), 32'd1);
      check_eq("sl_halt_pipeen", 32'(PipeEn), 32'd1);
      tick();
      Inst_D = NOP;
      for (int d = 0; d < 3; d++) begin
         check_eq("sl_drain_pchold", 32'(PcHold), 32'd1);
         check_eq("sl_drain_kill", 32'(FetchKill), 32'd1);
         check_eq("sl_drain_pipeen", 32'(PipeEn), 32'd1);
         check_eq("sl_drain_dumpsel", 32'(dif.DumpSel), 32'd0);
         tick();
      end
      check_eq("sl_dumpsel", 32'(dif.DumpSel), 32'd1);
      check_eq("sl_dump_pipeen", 32'(PipeEn), 32'd0);
      check_eq("sl_cycles", CycleCount, 32'd9);
      check_eq("sl_timeout", 32'(Timeout), 32'd0);
      run_dump(-1, 0, 8);
      check_eq("sl_done", 32'(Done), 32'd1);
      check_eq("sl_cycles_hold", CycleCount, 32'd9);

      // Wrong-path halt, START ignored, backpressured dump
      do_reset();
      pulse_start();
      check_eq("wp_cycles0", CycleCount, 32'd0);
      Inst_D = 32'hFFFF_FFFE;
      #1;
      check_eq("wp_near_halt_kill", 32'(FetchKill), 32'd0);
      tick();
      Inst_D = NOP;
      START = 1'b1;
      tick();
      START = 1'b0;
      check_eq("wp_still_run", 32'(PcHold), 32'd0);
      check_eq("wp_start_ignored", CycleCount, 32'd2);
      tick();
      Inst_D = HALT;
      #1;
      check_eq("wp_real_halt_kill", 32'(FetchKill), 32'd1);
      tick();
      Inst_D = NOP;
      tick(); tick(); tick();
      check_eq("wp_dumpsel", 32'(dif.DumpSel), 32'd1);
      check_eq("wp_cycles", CycleCount, 32'd7);
      run_dump(1, 5, 13);
      check_eq("wp_cycles_hold", CycleCount, 32'd7);
      pulse_start();
      check_eq("done_start_ignored", 32'(Done), 32'd1);
      check_eq("done_start_pipeen", 32'(PipeEn), 32'd0);
      check_eq("done_start_cycles", CycleCount, 32'd7);

      // Watchdog
      do_reset();
      pulse_start();
      for (int i = 0; i < 19; i++) tick();
      check_eq("wd_cycles19", CycleCount, 32'd19);
      check_eq("wd_pre_timeout", 32'(Timeout), 32'd0);
      check_eq("wd_pre_pchold", 32'(PcHold), 32'd0);
      tick();
      check_eq("wd_timeout", 32'(Timeout), 32'd1);
      check_eq("wd_drain_kill", 32'(FetchKill), 32'd1);
      check_eq("wd_drain_pchold", 32'(PcHold), 32'd1);
      check_eq("wd_cycles20", CycleCount, 32'd20);
      tick(); tick(); tick();
      check_eq("wd_dumpsel", 32'(dif.DumpSel), 32'd1);
      check_eq("wd_cycles23", CycleCount, 32'd23);
      run_dump(-1, 0, 8);
      check_eq("wd_timeout_sticky", 32'(Timeout), 32'd1);
      check_eq("wd_done", 32'(Done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
